// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if
//   Frame push channel into the I2S transmit serializer.
//   master: drives s_valid, s_left, s_right; samples s_ready.
//   slave : samples s_valid, s_left, s_right; drives s_ready.
//   s_left / s_right are two's-complement channel samples of DATA_WIDTH bits.
interface i2s_tx_serializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                         s_valid;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] s_left;
    logic signed [DATA_WIDTH-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Buffers stereo frames in a FIFO and serializes them as Philips I2S
//   (MSB one BCLK after the LRCLK edge).
// Ports:
//   ACLK, ARESET     clock, asynchronous active-high reset
//   enable           1 = run the serializer; stopping happens at frame end
//   s (slave)        frame push channel: s_valid/s_ready/s_left/s_right
//   fifo_level       frames currently stored
//   frame_pulse      one-cycle pulse per frame latched for transmission
//   underrun         sticky: a frame latch found the FIFO empty
//   underrun_clr     clears underrun (a simultaneous set wins)
//   bclk/lrclk/sdata I2S bit clock, word select (1 = right), serial data
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            enable,
    i2s_tx_serializer_if.slave              s,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            frame_pulse,
    output logic                            underrun,
    input  logic                            underrun_clr,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            sdata
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int B_W        = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCLK_DIV + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [DIV_W-1:0]             div_q, div_d;
    logic [B_W-1:0]               b_q, b_d, b_nxt;
    logic                         bclk_q, bclk_d;
    logic                         lrclk_q, lrclk_d;
    logic                         sdata_q, sdata_d;
    logic                         pulse_q, pulse_d;
    logic                         underrun_q, underrun_d;
    logic [LVL_W-1:0]             count_q, count_d;
    logic                         s_ready_q, s_ready_d;
    logic [PTR_W-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic signed [DATA_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic signed [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic                         push, pop, latch;

    // Bit driven while the frame counter sits at b: position b-1 of the
    // frame, so b=0 still carries the last right-slot bit of the old frame.
    function automatic logic serial_bit(input logic [B_W-1:0] b,
                                        input logic [DATA_WIDTH-1:0] l,
                                        input logic [DATA_WIDTH-1:0] r);
        int p;
        int idx;
        logic [DATA_WIDTH-1:0] w;
        p   = (int'(b) + FRAME_BITS - 1) % FRAME_BITS;
        idx = p % SLOT_WIDTH;
        w   = (p >= SLOT_WIDTH) ? r : l;
        if (idx >= DATA_WIDTH) begin
            return 1'b0;
        end
        w = w >> (DATA_WIDTH - 1 - idx);
        return w[0];
    endfunction

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        b_d        = b_q;
        b_nxt      = '0;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        pulse_d    = 1'b0;
        underrun_d = underrun_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        latch      = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end
            end
            ST_RUN: begin
                if (div_q == DIV_W'(BCLK_DIV - 1)) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        // Falling toggle: advance the frame bit counter.
                        b_nxt = (b_q == B_W'(FRAME_BITS - 1)) ? '0 : b_q + 1'b1;
                        if (b_nxt == '0 && !enable) begin
                            state_d = ST_IDLE;
                            bclk_d  = 1'b0;
                            b_d     = '0;
                            lrclk_d = 1'b0;
                            sdata_d = 1'b0;
                        end else begin
                            b_d = b_nxt;
                            if (b_nxt == B_W'(1)) begin
                                latch   = 1'b1;
                                pulse_d = 1'b1;
                                if (count_q != '0) begin
                                    pop    = 1'b1;
                                    tx_l_d = mem_l[rd_q];
                                    tx_r_d = mem_r[rd_q];
                                end else begin
                                    tx_l_d = '0;
                                    tx_r_d = '0;
                                end
                            end
                            lrclk_d = (b_nxt >= B_W'(SLOT_WIDTH));
                            sdata_d = serial_bit(b_nxt, tx_l_d, tx_r_d);
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch && count_q == '0) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        // s_ready is the registered view of the count, so a same-cycle pop
        // never admits an extra push.
        push      = s.s_valid && s_ready_q;
        count_d   = count_q + LVL_W'(push) - LVL_W'(pop);
        s_ready_d = (count_d < LVL_W'(FIFO_DEPTH));
        wr_d      = wr_q + PTR_W'(push);
        rd_d      = rd_q + PTR_W'(pop);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            b_q        <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            pulse_q    <= 1'b0;
            underrun_q <= 1'b0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            b_q        <= b_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            pulse_q    <= pulse_d;
            underrun_q <= underrun_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    // Sample storage: pointers/count carry the reset, contents need none.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_l[wr_q] <= s.s_left;
            mem_r[wr_q] <= s.s_right;
        end
        tx_l_q <= tx_l_d;
        tx_r_q <= tx_r_d;
    end

    assign s.s_ready   = s_ready_q;
    assign fifo_level  = count_q;
    assign frame_pulse = pulse_q;
    assign underrun    = underrun_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: default instance against a frame-level
// reference model, plus a DATA_WIDTH=SLOT_WIDTH=16, BCLK_DIV=1 instance.
module tb_i2s_tx_serializer;
    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int DIV = 4;
    localparam int DEP = 4;
    localparam int FR  = 2 * SW;
    localparam logic [8:0] RST_VEC = {1'b1, 3'd0, 5'd0};

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       enable, underrun_clr;
    logic [2:0] fifo_level;
    logic       frame_pulse, underrun, bclk, lrclk, sdata;

    logic       en2;
    logic [2:0] level2;
    logic       pulse2, und2, bclk2, lr2, sd2;

    i2s_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();
    i2s_tx_serializer_if #(.DATA_WIDTH(16)) bus2 ();

    i2s_tx_serializer #(
        .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV), .FIFO_DEPTH(DEP)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .s(bus),
        .fifo_level(fifo_level), .frame_pulse(frame_pulse), .underrun(underrun),
        .underrun_clr(underrun_clr), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
    );

    i2s_tx_serializer #(
        .DATA_WIDTH(16), .SLOT_WIDTH(16), .BCLK_DIV(1), .FIFO_DEPTH(4)
    ) dut2 (
        .ACLK(ACLK), .ARESET(ARESET), .enable(en2), .s(bus2),
        .fifo_level(level2), .frame_pulse(pulse2), .underrun(und2),
        .underrun_clr(1'b0), .bclk(bclk2), .lrclk(lr2), .sdata(sd2)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: frame queue plus time since RUN entry; bclk, bit
    // index and latch instants follow from plain arithmetic on that time.
    logic [2*DW-1:0] m_q[$];
    bit              m_run = 1'b0;
    int              m_t = 0;
    logic [DW-1:0]   m_l = '0, m_r = '0;
    bit              m_pulse = 1'b0, m_und = 1'b0;

    function automatic int m_b();
        return (m_t / (2 * DIV)) % FR;
    endfunction

    task automatic model_step();
        bit acc, empty, latch;
        if (ARESET) begin
            m_q.delete();
            m_run = 1'b0; m_t = 0; m_pulse = 1'b0; m_und = 1'b0;
            return;
        end
        acc   = bus.s_valid && (m_q.size() < DEP);
        empty = (m_q.size() == 0);
        latch = 1'b0;
        if (!m_run) begin
            if (enable) begin m_run = 1'b1; m_t = 0; end
        end else begin
            m_t++;
            if (m_t % (2 * DIV) == 0) begin
                if ((m_t / (2 * DIV)) % FR == 0 && !enable) m_run = 1'b0;
                else if ((m_t / (2 * DIV)) % FR == 1) latch = 1'b1;
            end
        end
        if (latch) begin
            if (empty) {m_l, m_r} = '0;
            else {m_l, m_r} = m_q.pop_front();
        end
        if (latch && empty) m_und = 1'b1;
        else if (underrun_clr) m_und = 1'b0;
        m_pulse = latch;
        if (acc) m_q.push_back({bus.s_left, bus.s_right});
    endtask

    function automatic logic [8:0] exp_vec();
        int k, b;
        logic [63:0] w;
        logic bc, lr, sd;
        bc = 1'b0; lr = 1'b0; sd = 1'b0;
        if (m_run) begin
            k  = m_t / (2 * DIV);
            b  = k % FR;
            bc = ((m_t / DIV) % 2) == 1;
            lr = (b >= SW);
            if (k > 0) begin
                w  = {m_l, 8'h00, m_r, 8'h00};
                w  = w >> (FR - 1 - ((b + FR - 1) % FR));
                sd = w[0];
            end
        end
        return {(m_q.size() < DEP), 3'(m_q.size()), m_pulse, m_und, bc, lr, sd};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {bus.s_ready, fifo_level, frame_pulse, underrun, bclk, lrclk, sdata};
    endfunction

    task automatic cycle();
        @(posedge ACLK);
        model_step();
        @(negedge ACLK);
        chk("cyc", obs_vec(), exp_vec());
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit acc;
        bus.s_valid = 1'b1; bus.s_left = l; bus.s_right = r;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = (m_q.size() < DEP);
            cycle();
        end
        bus.s_valid = 1'b0;
        chk("push_acc", acc, 1);
    endtask

    task automatic wait_pulse(output int n);
        bit got;
        n = 0; got = 1'b0;
        for (int i = 1; i <= 2000 && !got; i++) begin
            cycle();
            if (frame_pulse) begin n = i; got = 1'b1; end
        end
        chk("pulse_seen", got, 1);
    endtask

    int          n, cnt, nrise, nfall, r1, r2;
    logic        pb, pb2;
    logic [63:0] cap_d, cap_l;
    logic [31:0] cap2;
    logic [15:0] l1, rr1, l2, rr2;
    int          rates[4] = '{0, 25, 300, 700};
    int          rate;

    initial begin
        ARESET = 1'b1; enable = 1'b0; underrun_clr = 1'b0;
        bus.s_valid = 1'b0; bus.s_left = '0; bus.s_right = '0;
        en2 = 1'b0; bus2.s_valid = 1'b0; bus2.s_left = '0; bus2.s_right = '0;

        repeat (2) cycle();
        chk("rst_vec", obs_vec(), RST_VEC);
        ARESET = 1'b0;
        cycle();
        chk("idle_vec", obs_vec(), RST_VEC);

        // Known frame, then underrun frames.
        push_frame(24'hA5A5A5, 24'h5A5A5A);
        chk("lvl_one", fifo_level, 1);
        enable = 1'b1;
        wait_pulse(n);
        chk("startup_lat", n, 2 * DIV + 1);
        pb = bclk; nrise = 0; cap_d = '0; cap_l = '0;
        for (int i = 0; i < 1000 && nrise < 64; i++) begin
            cycle();
            if (bclk && !pb) begin
                cap_d = {cap_d[62:0], sdata};
                cap_l = {cap_l[62:0], lrclk};
                nrise++;
            end
            pb = bclk;
        end
        chk("a5_data", cap_d, 64'hA5A5A500_5A5A5A00);
        chk("a5_lrclk", cap_l, 64'h0000_0001_FFFF_FFFE);
        wait_pulse(n);
        chk("und_set", underrun, 1);
        repeat (50) cycle();
        underrun_clr = 1'b1;
        cycle();
        underrun_clr = 1'b0;
        chk("und_clr", underrun, 0);
        wait_pulse(n);
        chk("und_again", underrun, 1);
        wait_pulse(n);
        chk("frame_period", n, 2 * DIV * FR);

        // Stop at frame end.
        for (int i = 0; i < 3000 && !(m_run && m_b() == 10); i++) cycle();
        enable = 1'b0;
        for (int i = 0; i < 1000 && m_run; i++) cycle();
        chk("stop_bclk", bclk, 0);
        chk("stop_lrclk", lrclk, 0);

        // Fill the FIFO while idle; fifth frame waits for the first pop.
        for (int i = 0; i < 4; i++) push_frame(24'($urandom), 24'($urandom));
        chk("full_ready", bus.s_ready, 0);
        chk("full_lvl", fifo_level, 4);
        enable = 1'b1;
        push_frame(24'($urandom), 24'($urandom));
        chk("lvl_back4", fifo_level, 4);

        // Drop enable mid-frame; queued frames stay put.
        for (int i = 0; i < 3000 && !(m_run && m_b() == 10); i++) cycle();
        enable = 1'b0;
        for (int i = 0; i < 1000 && m_run; i++) cycle();
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (frame_pulse) cnt++;
        end
        chk("no_pulse", cnt, 0);
        chk("held_lvl", fifo_level, 4);

        // Asynchronous reset in the right slot with frames queued.
        enable = 1'b1;
        for (int i = 0; i < 3000 && !(m_run && m_b() == 40); i++) cycle();
        chk("pre_lvl", fifo_level, 3);
        ARESET = 1'b1;
        #1;
        chk("arst_vec", obs_vec(), RST_VEC);
        repeat (2) cycle();
        ARESET = 1'b0;
        wait_pulse(n);
        chk("restart_lat", n, 2 * DIV + 1);

        // Randomized traffic, enable and clear activity.
        for (int blk = 0; blk < 24; blk++) begin
            rate = rates[$urandom_range(0, 3)];
            for (int c = 0; c < 1000; c++) begin
                bus.s_valid  = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
                bus.s_left   = 24'($urandom);
                bus.s_right  = 24'($urandom);
                underrun_clr = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 699) == 0) enable = ~enable;
                cycle();
            end
        end
        bus.s_valid = 1'b0; underrun_clr = 1'b0; enable = 1'b0;

        // Narrow instance: full-width slots, BCLK_DIV=1.
        l1 = 16'($urandom); rr1 = 16'($urandom) | 16'h0001;
        l2 = 16'($urandom); rr2 = 16'($urandom);
        bus2.s_valid = 1'b1; bus2.s_left = l1; bus2.s_right = rr1;
        cycle();
        bus2.s_left = l2; bus2.s_right = rr2;
        cycle();
        bus2.s_valid = 1'b0;
        chk("p2_lvl", level2, 2);
        en2 = 1'b1;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            cycle();
            if (pulse2) n = i;
        end
        chk("p2_lat", n, 3);
        chk("p2_msb", sd2, l1[15]);
        pb2 = bclk2; nrise = 0; nfall = 0; r1 = -1; r2 = -1; cap2 = '0;
        for (int i = 1; i <= 200 && nfall < 32; i++) begin
            cycle();
            if (bclk2 && !pb2) begin
                if (nrise < 32) cap2 = {cap2[30:0], sd2};
                nrise++;
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (!bclk2 && pb2) begin
                nfall++;
                if (nfall == 31) begin
                    chk("p2_b0_lsb", sd2, rr1[0]);
                    chk("p2_b0_lr", lr2, 0);
                end
                if (nfall == 32) begin
                    chk("p2_pulse2", pulse2, 1);
                    chk("p2_msb2", sd2, l2[15]);
                end
            end
            pb2 = bclk2;
        end
        chk("p2_falls", nfall, 32);
        chk("p2_period", r2 - r1, 2);
        chk("p2_frame", cap2, {l1, rr1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Transmit datapath stage of the I2S codec peripheral. Sits directly downstream of the AXI register/interrupt block, which pushes stereo sample frames into this block. The block buffers frames in a small FIFO and serializes them onto BCLK/LRCLK/SDATA in standard Philips I2S format (MSB one BCLK after the LRCLK edge). It reports FIFO level, a per-frame pulse for interrupt generation, and a sticky underrun flag.

## Interface
Parameters:
- DATA_WIDTH, 24, bits per channel sample; must be 1..SLOT_WIDTH.
- SLOT_WIDTH, 32, BCLK periods per channel slot.
- BCLK_DIV, 4, ACLK cycles per BCLK half-period; must be ≥ 1.
- FIFO_DEPTH, 4, stereo frames buffered; power of two, ≥ 2.

Ports:
- ACLK  in  1  sole clock.
- ARESET  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run the serializer.
- s_valid  in  1  frame offered.
- s_ready  out  1  FIFO can accept a frame.
- s_left  in  DATA_WIDTH  left sample, two's complement.
- s_right  in  DATA_WIDTH  right sample.
- fifo_level  out  clog2(FIFO_DEPTH+1)  frames currently stored.
- frame_pulse  out  1  one-ACLK pulse per frame latched for transmission.
- underrun  out  1  sticky; a frame latch found the FIFO empty.
- underrun_clr  in  1  clears underrun.
- bclk  out  1  bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data.

## Operation
- FIFO push: on s_valid && s_ready. s_ready = (fifo_level < FIFO_DEPTH), registered from the count only. A pop in the same cycle does not raise s_ready in that cycle.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged.
- States:
  - IDLE: bclk=0, lrclk=0, sdata=0, bit counter b=0, divider=0.
  - RUN: entered on the first ACLK edge with enable=1 in IDLE.
- Divider: counts 0..BCLK_DIV-1 in RUN. At terminal count bclk toggles and the divider wraps.
- On each bclk falling toggle, b advances modulo 2*SLOT_WIDTH.
- lrclk = (b ≥ SLOT_WIDTH).
- Data position: p = (b−1) mod 2*SLOT_WIDTH; channel = p / SLOT_WIDTH; idx = p mod SLOT_WIDTH.
- sdata = sample[channel][DATA_WIDTH−1−idx] if idx < DATA_WIDTH, else 0. At b=0 this is the previous frame's right idx=SLOT_WIDTH−1 bit.
- Frame latch: on the falling toggle that enters b=1.
  - Pop FIFO head into the transmit registers and pulse frame_pulse.
  - If the FIFO is empty, latch zeros, still pulse frame_pulse, and set underrun.
- underrun: set has priority over underrun_clr in the same cycle.
- Stop: when enable=0 and the falling toggle would enter b=0, enter IDLE instead. The current frame always completes. enable dropping and rising again within a frame does not stop.
- FIFO pushes are accepted in both states.

## Timing
- Reset values: s_ready=1, fifo_level=0, frame_pulse=0, underrun=0, bclk=0, lrclk=0, sdata=0, state IDLE, FIFO empty.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous) and the FIFO contents are discarded.
- Transition timing: sdata and lrclk change in the same ACLK cycle as the bclk falling toggle and are stable at the bclk rise.
- BCLK period = 2*BCLK_DIV ACLK cycles. Frame = 2*SLOT_WIDTH BCLK periods (512 ACLK at defaults).
- Start-up from IDLE: bclk rises BCLK_DIV cycles after RUN entry. The first falling toggle at 2*BCLK_DIV cycles latches the first frame; the left MSB is on sdata from that cycle.
- frame_pulse is asserted in the same cycle as the latching bclk fall.
- fifo_level and s_ready update the cycle after the push or pop edge.
- All outputs are registered.

## Test plan
- Reset, FIFO empty, enable=1.
  - Every frame transmits zeros; frame_pulse every 512 cycles.
  - underrun=1 from the first latch; underrun_clr pulse clears it for one frame only.
- Push L=0xA5A5A5, R=0x5A5A5A, then enable.
  - Capture sdata on bclk rise: left MSB at b=1.
  - Bits b=1..24 are 0xA5A5A5, b=25..32 zero; right 0x5A5A5A at b=33..56.
  - lrclk high for b=32..63.
- Push 5 frames back-to-back with enable=0.
  - s_ready falls after the 4th; fifo_level=4; the 5th is held until the first latch pops.
  - Then fifo_level returns to 4 (push and pop overlap).
- Drop enable at b=10.
  - Frame completes; IDLE entered at the b=63→0 boundary with bclk=0.
  - No further frame_pulse; the next frame stays in the FIFO.
- Assert ARESET at b=40 with 3 frames queued.
  - Outputs immediately take reset values, fifo_level=0, s_ready=1.
  - After release with enable=1, timing restarts from start-up.
- Parameter sweep: DATA_WIDTH=SLOT_WIDTH=16, BCLK_DIV=1.
  - At b=0, sdata equals the previous right LSB.
  - The bclk period is 2 ACLK cycles.
